// File: rtl/priority_code_decoder_if.sv
// Handshake bundle for priority_code_decoder: code input side and one-hot output side.
// master = producer/consumer environment, slave = the decoder itself.
interface priority_code_decoder_if #(
    parameter int WIDTH  = 16,
    parameter int CODE_W = 4
);
    logic              enable_dut;
    logic [CODE_W-1:0] code_in_dut;
    logic              code_valid_dut;
    logic              code_ready_dut;
    logic [WIDTH-1:0]  onehot_out_dut;
    logic              onehot_valid_dut;
    logic              onehot_ready_dut;
    logic              none_dut;

    modport master (
        output enable_dut,
        output code_in_dut,
        output code_valid_dut,
        output onehot_ready_dut,
        input  code_ready_dut,
        input  onehot_out_dut,
        input  onehot_valid_dut,
        input  none_dut
    );

    modport slave (
        input  enable_dut,
        input  code_in_dut,
        input  code_valid_dut,
        input  onehot_ready_dut,
        output code_ready_dut,
        output onehot_out_dut,
        output onehot_valid_dut,
        output none_dut
    );
endinterface

// File: rtl/priority_code_decoder.sv
// Buffered priority-code to one-hot decoder: code k (1..15) -> bit k-1, code 0 -> no request.
// Optional PRIO_DECODER_STATS_EN adds decode_count_dut, a saturating count of non-zero words delivered.
module priority_code_decoder #(
    parameter int WIDTH  = 16,
    parameter int CODE_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic clk_dut,
    input  logic rst_dut,
    priority_code_decoder_if.slave bus
`ifdef PRIO_DECODER_STATS_EN
    ,
    output logic [15:0] decode_count_dut
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;
    logic             not_full;
    logic             not_empty;
    logic [WIDTH-1:0] decoded;
    logic [WIDTH-1:0] head;

    // Bit WIDTH-1 would need code WIDTH, which does not fit in CODE_W bits, so it stays clear.
    always_comb begin
        decoded = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            decoded[i] = bus.enable_dut && ({1'b0, bus.code_in_dut} == (CODE_W + 1)'(i + 1));
        end
    end

    assign not_full  = (count < CNT_W'(DEPTH));
    assign not_empty = (count != '0);
    assign head      = mem[rd_ptr];

    // No full-bypass: a pop while full does not open a push slot in the same cycle.
    assign push = bus.code_valid_dut && bus.code_ready_dut;
    assign pop  = bus.onehot_valid_dut && bus.onehot_ready_dut;

    assign bus.code_ready_dut   = !rst_dut && not_full;
    assign bus.onehot_valid_dut = not_empty;
    assign bus.onehot_out_dut   = not_empty ? head : '0;
    assign bus.none_dut         = not_empty && (head == '0);

    always_ff @(posedge clk_dut or posedge rst_dut) begin
        if (rst_dut) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= decoded;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef PRIO_DECODER_STATS_EN
    logic [15:0] decode_count_q;

    always_ff @(posedge clk_dut or posedge rst_dut) begin
        if (rst_dut) begin
            decode_count_q <= '0;
        end else if (pop && (head != '0) && (decode_count_q != '1)) begin
            decode_count_q <= decode_count_q + 16'd1;
        end
    end

    assign decode_count_dut = decode_count_q;
`endif
endmodule

// File: tb/tb_priority_code_decoder.sv
// Scoreboard bench for priority_code_decoder: driver pushes expected words on accept,
// a negedge monitor compares the FIFO head and pops on output accept.
module tb_priority_code_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    priority_code_decoder_if #(.WIDTH(16), .CODE_W(4)) bus ();

`ifdef PRIO_DECODER_STATS_EN
    logic [15:0] decode_count;
`endif

    priority_code_decoder #(.WIDTH(16), .CODE_W(4), .DEPTH(2)) dut (
        .clk_dut (clk),
        .rst_dut (rst),
        .bus     (bus)
`ifdef PRIO_DECODER_STATS_EN
        ,
        .decode_count_dut (decode_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    logic [15:0] sweep_exp [16] = '{
        16'h0000, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040,
        16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000
    };

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] code, input logic en, input logic [15:0] exp);
        bit ok;
        bit done = 0;
        bus.code_in_dut    = code;
        bus.enable_dut     = en;
        bus.code_valid_dut = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            ok = bus.code_ready_dut;
            @(posedge clk);
            #1;
            if (ok) begin
                exp_q.push_back(exp);
                done = 1;
            end
        end
        bus.code_valid_dut = 1'b0;
        if (!done) check("send_timeout", 32'(code), 32'hFFFF_FFFF);
    endtask

    task automatic wait_empty();
        bit done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: the queue mirrors FIFO occupancy at every negedge.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("valid_vs_queue", 32'(bus.onehot_valid_dut), 32'(exp_q.size() != 0));
                if (bus.onehot_valid_dut && exp_q.size() != 0) begin
                    e = exp_q[0];
                    check("onehot_out", 32'(bus.onehot_out_dut), 32'(e));
                    check("none", 32'(bus.none_dut), 32'(e == 16'h0000));
                    if (bus.onehot_ready_dut) void'(exp_q.pop_front());
                end else if (!bus.onehot_valid_dut) begin
                    check("idle_out", 32'(bus.onehot_out_dut), 32'd0);
                    check("idle_none", 32'(bus.none_dut), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable_dut       = 1'b1;
        bus.code_in_dut      = '0;
        bus.code_valid_dut   = 1'b0;
        bus.onehot_ready_dut = 1'b1;
        rst = 1'b1;

        // Reset held three cycles
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_valid", 32'(bus.onehot_valid_dut), 32'd0);
            check("rst_out", 32'(bus.onehot_out_dut), 32'd0);
            check("rst_none", 32'(bus.none_dut), 32'd0);
            check("rst_code_ready", 32'(bus.code_ready_dut), 32'd0);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_code_ready", 32'(bus.code_ready_dut), 32'd1);
        check("post_rst_valid", 32'(bus.onehot_valid_dut), 32'd0);
        @(posedge clk);
        #1;

        // Full sweep, back-to-back
        for (int k = 0; k < 16; k++) send(4'(k), 1'b1, sweep_exp[k]);
        wait_empty();

        // Enable gating
        send(4'd5, 1'b0, 16'h0000);
        send(4'd5, 1'b1, 16'h0010);
        wait_empty();

        // Backpressure: fill, then hold code 9
        bus.onehot_ready_dut = 1'b0;
        send(4'd3, 1'b1, 16'h0004);
        send(4'd7, 1'b1, 16'h0040);
        bus.code_in_dut    = 4'd9;
        bus.enable_dut     = 1'b1;
        bus.code_valid_dut = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("full_code_ready", 32'(bus.code_ready_dut), 32'd0);
            check("held_head", 32'(bus.onehot_out_dut), 32'h0004);
        end
        @(posedge clk);
        #1 bus.onehot_ready_dut = 1'b1;
        send(4'd9, 1'b1, 16'h0100);
        wait_empty();

        // Asynchronous reset with two words buffered
        bus.onehot_ready_dut = 1'b0;
        send(4'd1, 1'b1, 16'h0001);
        send(4'd2, 1'b1, 16'h0002);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.onehot_valid_dut), 32'd0);
        check("async_rst_out", 32'(bus.onehot_out_dut), 32'd0);
        check("async_rst_ready", 32'(bus.code_ready_dut), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("after_rst_valid", 32'(bus.onehot_valid_dut), 32'd0);
        check("after_rst_ready", 32'(bus.code_ready_dut), 32'd1);
        @(posedge clk);
        #1 bus.onehot_ready_dut = 1'b1;
        send(4'd6, 1'b1, 16'h0020);
        send(4'd15, 1'b1, 16'h4000);
        wait_empty();

`ifdef PRIO_DECODER_STATS_EN
        // Counter restarted at the mid-flight reset; 6 and 15 were delivered since
        check("stats_after_rst", 32'(decode_count), 32'd2);
        rst = 1'b1;
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        check("stats_reset", 32'(decode_count), 32'd0);
        send(4'd1, 1'b1, 16'h0001);
        send(4'd0, 1'b1, 16'h0000);
        send(4'd2, 1'b1, 16'h0002);
        wait_empty();
        check("stats_count", 32'(decode_count), 32'd2);
        force dut.decode_count_q = 16'hFFFF;
        #1 release dut.decode_count_q;
        send(4'd4, 1'b1, 16'h0008);
        wait_empty();
        check("stats_saturate", 32'(decode_count), 32'h0000_FFFF);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/priority_code_decoder.md
# priority_code_decoder

Buffered decoder that expands 4-bit priority codes back into one-hot request vectors, using the same code convention as the 16-input priority encoder. Code k (1..15) represents input bit k-1, and code 0 represents no request. The block sits on the consumer side of the encoder. It accepts codes over a valid/ready handshake, decodes each code at acceptance, stores the result in a small FIFO, and presents one-hot words to downstream logic over a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 16, one-hot output width; must equal 2**CODE_W.
- CODE_W, 4, code input width.
- DEPTH, 2, FIFO entries; power of two, ≥2.

Ports:
- clk_dut  in  1  single clock; all state updates on rising edge.
- rst_dut  in  1  reset, asynchronous, active-high.
- enable_dut  in  1  sampled at acceptance; 0 forces the stored word to all-zero.
- code_in_dut  in  CODE_W  priority code.
- code_valid_dut  in  1  code_in_dut valid.
- code_ready_dut  out  1  block can accept a code this cycle.
- onehot_out_dut  out  WIDTH  decoded word at FIFO head.
- onehot_valid_dut  out  1  onehot_out_dut valid.
- onehot_ready_dut  in  1  downstream accepts the word.
- none_dut  out  1  head word is all-zero (code 0 or disabled); qualified by onehot_valid_dut.

## Operation
- Input accept: code_valid_dut & code_ready_dut at a rising edge.
- Output accept: onehot_valid_dut & onehot_ready_dut at a rising edge.
- Decode at accept:
  - enable_dut=1 and code k≠0: stored word = 1<<(k-1).
  - Code 0 or enable_dut=0: stored word = 0.
  - Bit WIDTH-1 is never set (code range 1..15 maps to bits 0..14).
- The FIFO holds DEPTH decoded words, with write pointer, read pointer and occupancy count; pointers wrap modulo DEPTH.
- code_ready_dut = !rst_dut && (count < DEPTH). There is no bypass when full: a simultaneous pop while full does not enable a push in that cycle.
- onehot_valid_dut = (count != 0).
- onehot_out_dut = head word when valid, else all-zero.
- none_dut = onehot_valid_dut && (head word == 0).
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- A pop with count=0 cannot occur because valid is low.
- While onehot_valid_dut=1 and onehot_ready_dut=0, onehot_out_dut and none_dut hold stable.
- Changes on code_in_dut or enable_dut while not accepted have no effect.

## Timing
- Reset (async assert, sync-safe deassert): count=0, both pointers=0, FIFO storage cleared to 0.
- Output values during and after reset:
  - onehot_valid_dut=0.
  - onehot_out_dut=0.
  - none_dut=0.
  - code_ready_dut=0 while rst_dut=1, then 1 after reset releases.
- Latency: a code accepted at edge N appears on onehot_out_dut with onehot_valid_dut=1 after edge N, provided the FIFO was empty.
- Throughput: one word per cycle sustained when both sides stream and 0<count<DEPTH.
- Reset asserted mid-transfer: all buffered words are discarded immediately and no partial handshake completes.

## Configuration
- PRIO_DECODER_STATS_EN defined:
  - Adds output port decode_count_dut (16 bits), reset to 0.
  - The counter increments on each output accept whose word is non-zero and saturates at 16'hFFFF.
- PRIO_DECODER_STATS_EN undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset test: hold rst_dut for 3 cycles, then release. Required: all outputs 0 during reset; code_ready_dut=1 on the first cycle after release.
- Full decode sweep: enable_dut=1, onehot_ready_dut=1, codes 0..15 streamed back-to-back.
  - Required: outputs are 0, 0x0001, 0x0002, … 0x4000, each one cycle after its accept.
  - Required: none_dut=1 only for code 0.
- Disable test: enable_dut=0 while sending code 5 → onehot_out_dut=0 with none_dut=1. Then enable_dut=1 while sending code 5 → 0x0010.
- Backpressure test: onehot_ready_dut=0, send codes 3, 7, 9.
  - Required: codes 3 and 7 accepted, then code_ready_dut=0 and 9 is held.
  - Required: onehot_out_dut stays 0x0004.
  - Then raise onehot_ready_dut → outputs 0x0004, 0x0040, 0x0100 in order.
- Mid-flight reset: two words buffered, assert rst_dut asynchronously between edges → onehot_valid_dut drops immediately; after release the FIFO is empty.
- Stats (PRIO_DECODER_STATS_EN): deliver codes 1, 0, 2 → decode_count_dut=2. Force the counter to 16'hFFFF and deliver one more non-zero word → value stays 16'hFFFF.
